// File: rtl/cpu_pkg.sv
// Shared MIPS32 datapath constants and register-file types.
package cpu_pkg;

  localparam int REG_W  = 32;
  localparam int REG_AW = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]  reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve marks a pending producer, a write releases it.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW       = REG_AW,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 2**AW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic                i_rsv_en,
  input  logic [AW-1:0]       i_rsv_addr,
  input  logic [NREAD*AW-1:0] i_raddr,
  output logic [NREAD-1:0]    o_rbusy,
  output logic [DEPTH-1:0]    o_busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Reserve is applied after release so a same-cycle reissue keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_we)           w_busy_nxt[i_waddr]    = 1'b0;
    if (i_rsv_en)       w_busy_nxt[i_rsv_addr] = 1'b1;
    if (ZERO_REG != 0)  w_busy_nxt[0]          = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rbusy
    assign o_rbusy[k] = r_busy[i_raddr[k*AW +: AW]];
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/rf_param.sv
// Parametrised MIPS32 register file: NREAD combinational read ports, one write port,
// optional write-to-read bypass, hard-wired zero register and busy scoreboard.
module rf_param
  import cpu_pkg::*;
#(
  parameter int WIDTH    = REG_W,
  parameter int AW       = REG_AW,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 2**AW
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic [NREAD*AW-1:0]    i_raddr,
  output logic [NREAD*WIDTH-1:0] o_rdata,
  input  logic                   i_rsv_en,
  input  logic [AW-1:0]          i_rsv_addr,
  output logic [NREAD-1:0]       o_rbusy,
  output logic [DEPTH-1:0]       o_busy_vec
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok;

  assign w_wr_ok = i_we && !((ZERO_REG != 0) && (i_waddr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = i_raddr[k*AW +: AW];
    // Zero-register override sits above the bypass so r0 stays 0 even mid-write.
    assign o_rdata[k*WIDTH +: WIDTH] =
      ((ZERO_REG != 0) && (w_ra == '0))          ? '0      :
      ((BYPASS != 0) && i_we && (i_waddr == w_ra)) ? i_wdata :
                                                     r_mem[w_ra];
  end

  rf_scoreboard #(
    .AW       (AW),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (i_we),
    .i_waddr    (i_waddr),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_addr (i_rsv_addr),
    .i_raddr    (i_raddr),
    .o_rbusy    (o_rbusy),
    .o_busy_vec (o_busy_vec)
  );

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: one bypassing instance and one non-bypassing instance share stimulus.
module tb_rf_param;
  import cpu_pkg::*;

  localparam int W = 32;
  localparam int A = 5;
  localparam int N = 2;
  localparam int D = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           we;
  logic [A-1:0]   waddr;
  logic [W-1:0]   wdata;
  logic [N*A-1:0] raddr;
  logic           rsv_en;
  logic [A-1:0]   rsv_addr;

  logic [N*W-1:0] rdata, rdata_nb;
  logic [N-1:0]   rbusy, rbusy_nb;
  logic [D-1:0]   busy_vec, busy_vec_nb;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rf_param #(.WIDTH(W), .AW(A), .NREAD(N), .BYPASS(1), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_rbusy(rbusy), .o_busy_vec(busy_vec)
  );

  rf_param #(.WIDTH(W), .AW(A), .NREAD(N), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata_nb), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_rbusy(rbusy_nb), .o_busy_vec(busy_vec_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic set_raddr(input reg_addr_t a0, input reg_addr_t a1);
    raddr = {a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; rsv_en = 1'b0; waddr = '0; wdata = '0; rsv_addr = '0;
    set_raddr(5, 5);
    tick(); tick();
    idle();
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    n_total++;
    if (rdata[31:0] !== 32'hDEADBEEF) $display("FAIL preload_r5 got %h want %h", rdata[31:0], 32'hDEADBEEF);
    else n_pass++;
    rst = 1'b1;
    tick();
    idle();
    #1;
    n_total++;
    if (rdata[31:0] !== 32'h0) $display("FAIL reset_r5 got %h want %h", rdata[31:0], 32'h0);
    else n_pass++;
    n_total++;
    if (busy_vec !== '0) $display("FAIL reset_busy got %h want %h", busy_vec, 32'h0);
    else n_pass++;
    n_total++;
    if (rdata_nb[31:0] !== 32'h0) $display("FAIL reset_r5_nb got %h want %h", rdata_nb[31:0], 32'h0);
    else n_pass++;
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 7; wdata = 32'h12345678;
    set_raddr(1, 1);
    tick();
    idle();
    set_raddr(7, 7);
    #1;
    n_total++;
    if (rdata[31:0] !== 32'h12345678) $display("FAIL wr_rd_p0 got %h want %h", rdata[31:0], 32'h12345678);
    else n_pass++;
    n_total++;
    if (rdata[63:32] !== 32'h12345678) $display("FAIL wr_rd_p1 got %h want %h", rdata[63:32], 32'h12345678);
    else n_pass++;
    n_total++;
    if (rdata_nb[63:32] !== 32'h12345678) $display("FAIL wr_rd_p1_nb got %h want %h", rdata_nb[63:32], 32'h12345678);
    else n_pass++;
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 3; wdata = 32'hA5A5A5A5;
    set_raddr(7, 3);
    #1;
    n_total++;
    if (rdata[63:32] !== 32'hA5A5A5A5) $display("FAIL bypass_p1 got %h want %h", rdata[63:32], 32'hA5A5A5A5);
    else n_pass++;
    n_total++;
    if (rdata_nb[63:32] !== 32'h0) $display("FAIL nobypass_p1 got %h want %h", rdata_nb[63:32], 32'h0);
    else n_pass++;
    n_total++;
    if (rdata[31:0] !== 32'h12345678) $display("FAIL bypass_other_port got %h want %h", rdata[31:0], 32'h12345678);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (rdata_nb[63:32] !== 32'hA5A5A5A5) $display("FAIL nobypass_after got %h want %h", rdata_nb[63:32], 32'hA5A5A5A5);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 0; wdata = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 0;
    set_raddr(0, 0);
    #1;
    n_total++;
    if (rdata !== '0) $display("FAIL zero_bypass_cycle got %h want %h", rdata, 64'h0);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (rdata !== '0) $display("FAIL zero_after_write got %h want %h", rdata, 64'h0);
    else n_pass++;
    n_total++;
    if (rdata_nb !== '0) $display("FAIL zero_after_write_nb got %h want %h", rdata_nb, 64'h0);
    else n_pass++;
    n_total++;
    if (busy_vec !== '0) $display("FAIL zero_busy got %h want %h", busy_vec, 32'h0);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 9;
    set_raddr(9, 3);
    tick();
    idle();
    #1;
    n_total++;
    if (rbusy !== 2'b01) $display("FAIL rsv_rbusy got %b want %b", rbusy, 2'b01);
    else n_pass++;
    n_total++;
    if (busy_vec !== 32'h0000_0200) $display("FAIL rsv_busy_vec got %h want %h", busy_vec, 32'h0000_0200);
    else n_pass++;
    we = 1'b1; waddr = 9; wdata = 32'h55;
    #1;
    n_total++;
    if (rbusy[0] !== 1'b1) $display("FAIL release_same_cycle got %b want %b", rbusy[0], 1'b1);
    else n_pass++;
    n_total++;
    if (rdata[31:0] !== 32'h55) $display("FAIL release_bypass got %h want %h", rdata[31:0], 32'h55);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (rbusy !== 2'b00) $display("FAIL release_rbusy got %b want %b", rbusy, 2'b00);
    else n_pass++;
    n_total++;
    if (rdata_nb[31:0] !== 32'h55) $display("FAIL release_data got %h want %h", rdata_nb[31:0], 32'h55);
    else n_pass++;
    we = 1'b1; waddr = 9; wdata = 32'h66;
    rsv_en = 1'b1; rsv_addr = 9;
    tick();
    idle();
    #1;
    n_total++;
    if (busy_vec !== 32'h0000_0200) $display("FAIL wr_rsv_same_busy got %h want %h", busy_vec, 32'h0000_0200);
    else n_pass++;
    n_total++;
    if (rdata_nb[31:0] !== 32'h66) $display("FAIL wr_rsv_same_data got %h want %h", rdata_nb[31:0], 32'h66);
    else n_pass++;
    rsv_en = 1'b1; rsv_addr = 9;
    tick();
    idle();
    #1;
    n_total++;
    if (busy_vec !== 32'h0000_0200) $display("FAIL rsv_again got %h want %h", busy_vec, 32'h0000_0200);
    else n_pass++;
    we = 1'b1; waddr = 10; wdata = 32'h1010;
    rsv_en = 1'b1; rsv_addr = 11;
    set_raddr(11, 11);
    tick();
    idle();
    #1;
    n_total++;
    if (busy_vec !== 32'h0000_0A00) $display("FAIL wr_rsv_diff_busy got %h want %h", busy_vec, 32'h0000_0A00);
    else n_pass++;
    n_total++;
    if (rbusy !== 2'b11) $display("FAIL multi_port_rbusy got %b want %b", rbusy, 2'b11);
    else n_pass++;
    set_raddr(10, 31);
    #1;
    n_total++;
    if (rdata[31:0] !== 32'h1010) $display("FAIL wr_rsv_diff_data got %h want %h", rdata[31:0], 32'h1010);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    rsv_en = 1'b1; rsv_addr = 4;
    tick();
    rsv_addr = 6;
    tick();
    idle();
    #1;
    n_total++;
    if (busy_vec !== 32'h0000_0A50) $display("FAIL pre_reset_busy got %h want %h", busy_vec, 32'h0000_0A50);
    else n_pass++;
    rst = 1'b1;
    we = 1'b1; waddr = 6; wdata = 32'hCAFEF00D;
    rsv_en = 1'b1; rsv_addr = 12;
    tick();
    idle();
    set_raddr(6, 9);
    #1;
    n_total++;
    if (busy_vec !== '0) $display("FAIL mid_reset_busy got %h want %h", busy_vec, 32'h0);
    else n_pass++;
    n_total++;
    if (rdata[31:0] !== 32'h0) $display("FAIL mid_reset_r6 got %h want %h", rdata[31:0], 32'h0);
    else n_pass++;
    n_total++;
    if (rdata[63:32] !== 32'h0) $display("FAIL mid_reset_r9 got %h want %h", rdata[63:32], 32'h0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
